// File: rtl/accel_reg_pkg.sv
// Register map, reset values and SPI FSM states for the ADXL345-style SPI responder.
package accel_reg_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned AXIS_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_DEVID       = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [ADDR_W-1:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [ADDR_W-1:0] ADDR_INT_MAP     = 6'h2F;
    localparam logic [ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
    localparam logic [ADDR_W-1:0] ADDR_DATAX1      = 6'h33;
    localparam logic [ADDR_W-1:0] ADDR_DATAY0      = 6'h34;
    localparam logic [ADDR_W-1:0] ADDR_DATAY1      = 6'h35;
    localparam logic [ADDR_W-1:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [BYTE_W-1:0] RST_BW_RATE     = 8'h0A;
    localparam logic [BYTE_W-1:0] RST_POWER_CTL   = 8'h00;
    localparam logic [BYTE_W-1:0] RST_INT_ENABLE  = 8'h00;
    localparam logic [BYTE_W-1:0] RST_INT_MAP     = 8'h00;
    localparam logic [BYTE_W-1:0] RST_DATA_FORMAT = 8'h00;
    localparam logic [AXIS_W-1:0] RST_AXIS        = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    // True for the six axis data registers.
    function automatic logic is_data_addr(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_edge_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level  = chain[STAGES-1];
    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/accel_spi_responder.sv
// ADXL345-style SPI (mode 3) responder with sample capture and interrupt routing.
// Optional 3-wire read path enabled by defining ACCEL_SPI_3WIRE_EN.
module accel_spi_responder
    import accel_reg_pkg::*;
#(
    parameter logic [7:0]  DEVID_VAL   = 8'hE5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_csn,
    input  logic              spi_sclk,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic              sdio_out,
    output logic              sdio_oe,
    input  logic [AXIS_W-1:0] axis_x,
    input  logic [AXIS_W-1:0] axis_y,
    input  logic [AXIS_W-1:0] axis_z,
    input  logic              sample_valid,
    output logic [2:1]        interrupt
);

    logic sclk_s, sclk_rise_c, sclk_fall_c;
    logic csn_s, csn_rise_c, csn_fall_c;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic sdi_s;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .din(spi_sclk),
        .level(sclk_s), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn_sync (
        .clk(clk), .reset_n(reset_n), .din(spi_csn),
        .level(csn_s), .rise_c(csn_rise_c), .fall_c(csn_fall_c)
    );

    // SDI delayed by the same depth so it lines up with the SCLK edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sdi_sync <= '0;
        else          sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
    end
    assign sdi_s = sdi_sync[SYNC_STAGES-1];

    spi_state_t          state, state_nxt;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-2:0]   shift_in;
    logic                rw, mb, rd_hit;
    logic [ADDR_W-1:0]   addr, addr_inc_c, rd_addr_c;
    logic [BYTE_W-1:0]   tx_shift, rd_data_c, wbyte_c;
    logic [BYTE_W-1:0]   bw_rate, power_ctl, int_enable, int_map, data_format;
    logic [AXIS_W-1:0]   data_x, data_y, data_z, pend_x, pend_y, pend_z;
    logic                pend_valid, data_ready;
    logic                rise_act_c, byte_done_c, data_fall_c, drive_nxt_c;

    assign addr_inc_c  = addr + 6'd1;
    assign wbyte_c     = {shift_in, sdi_s};
    assign rise_act_c  = sclk_rise_c && (state != IDLE) && !csn_rise_c;
    assign byte_done_c = rise_act_c && (bit_cnt == 3'd7);
    assign data_fall_c = sclk_fall_c && (state == DATA) && rw && !csn_rise_c;
    assign drive_nxt_c = (state_nxt == DATA) && ((state == CMD) ? shift_in[6] : rw);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state; CSN rise aborts from anywhere
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (csn_fall_c) state_nxt = CMD;
            CMD:     if (byte_done_c) state_nxt = DATA;
            DATA:    state_nxt = DATA;
            default: state_nxt = IDLE;
        endcase
        if (csn_rise_c) state_nxt = IDLE;
    end

    // Read mux: command address while in CMD, next burst address otherwise
    always_comb begin
        rd_data_c = '0;
        rd_addr_c = (state == CMD) ? wbyte_c[ADDR_W-1:0] : addr_inc_c;
        case (rd_addr_c)
            ADDR_DEVID:       rd_data_c = DEVID_VAL;
            ADDR_BW_RATE:     rd_data_c = bw_rate;
            ADDR_POWER_CTL:   rd_data_c = power_ctl;
            ADDR_INT_ENABLE:  rd_data_c = int_enable;
            ADDR_INT_MAP:     rd_data_c = int_map;
            ADDR_DATA_FORMAT: rd_data_c = data_format;
            ADDR_DATAX0:      rd_data_c = data_x[7:0];
            ADDR_DATAX1:      rd_data_c = data_x[15:8];
            ADDR_DATAY0:      rd_data_c = data_y[7:0];
            ADDR_DATAY1:      rd_data_c = data_y[15:8];
            ADDR_DATAZ0:      rd_data_c = data_z[7:0];
            ADDR_DATAZ1:      rd_data_c = data_z[15:8];
            default:          rd_data_c = '0;
        endcase
    end

    // SPI shifting, address sequencing, register writes and read data out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            shift_in    <= '0;
            rw          <= 1'b0;
            mb          <= 1'b0;
            addr        <= '0;
            tx_shift    <= '0;
            rd_hit      <= 1'b0;
            spi_sdo     <= 1'b1;
            bw_rate     <= RST_BW_RATE;
            power_ctl   <= RST_POWER_CTL;
            int_enable  <= RST_INT_ENABLE;
            int_map     <= RST_INT_MAP;
            data_format <= RST_DATA_FORMAT;
        end else if (csn_rise_c) begin
            rd_hit  <= 1'b0;
            spi_sdo <= 1'b1;
        end else begin
            if ((state == IDLE) && csn_fall_c) begin
                bit_cnt <= '0;
                rd_hit  <= 1'b0;
            end
            if (rise_act_c) begin
                shift_in <= wbyte_c[BYTE_W-2:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done_c) begin
                if (state == CMD) begin
                    rw   <= shift_in[6];
                    mb   <= shift_in[5];
                    addr <= wbyte_c[ADDR_W-1:0];
                    if (shift_in[6]) tx_shift <= rd_data_c;
                end else if (rw) begin
                    if (is_data_addr(addr)) rd_hit <= 1'b1;
                    if (mb) begin
                        addr     <= addr_inc_c;
                        tx_shift <= rd_data_c;
                    end
                end else begin
                    if (mb) addr <= addr_inc_c;
                    case (addr)
                        ADDR_BW_RATE:     bw_rate     <= wbyte_c;
                        ADDR_POWER_CTL:   power_ctl   <= wbyte_c;
                        ADDR_INT_ENABLE:  int_enable  <= wbyte_c;
                        ADDR_INT_MAP:     int_map     <= wbyte_c;
                        ADDR_DATA_FORMAT: data_format <= wbyte_c;
                        default: ;
                    endcase
                end
            end
            if (data_fall_c) begin
                spi_sdo  <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // Sample capture: direct while deselected, buffered until CSN rise otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_x     <= RST_AXIS;
            data_y     <= RST_AXIS;
            data_z     <= RST_AXIS;
            pend_x     <= RST_AXIS;
            pend_y     <= RST_AXIS;
            pend_z     <= RST_AXIS;
            pend_valid <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            if (csn_rise_c) begin
                if (pend_valid) begin
                    data_x     <= pend_x;
                    data_y     <= pend_y;
                    data_z     <= pend_z;
                    data_ready <= 1'b1;
                    pend_valid <= 1'b0;
                end else if (rd_hit) begin
                    data_ready <= 1'b0;
                end
            end
            if (sample_valid) begin
                if (csn_s) begin
                    data_x     <= axis_x;
                    data_y     <= axis_y;
                    data_z     <= axis_z;
                    data_ready <= 1'b1;
                end else begin
                    pend_x     <= axis_x;
                    pend_y     <= axis_y;
                    pend_z     <= axis_z;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    // Interrupt routing: INT_MAP[7] selects INT2 over INT1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) interrupt <= '0;
        else interrupt <= {int_map[7] & data_ready & int_enable[7],
                           ~int_map[7] & data_ready & int_enable[7]};
    end

`ifdef ACCEL_SPI_3WIRE_EN
    logic three_wire_c;
    assign three_wire_c = data_format[6];

    // Output enables steered by DATA_FORMAT[6]; SDIO mirrors SDO timing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_sdo_oe <= 1'b0;
            sdio_oe    <= 1'b0;
            sdio_out   <= 1'b0;
        end else begin
            spi_sdo_oe <= drive_nxt_c & ~three_wire_c;
            sdio_oe    <= drive_nxt_c & three_wire_c;
            if (csn_rise_c)       sdio_out <= 1'b0;
            else if (data_fall_c) sdio_out <= tx_shift[7];
        end
    end
`else
    // Output enable follows the read data phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) spi_sdo_oe <= 1'b0;
        else          spi_sdo_oe <= drive_nxt_c;
    end

    assign sdio_out = 1'b0;
    assign sdio_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_accel_spi_responder.sv
// Scoreboard bench for accel_spi_responder: SPI mode-3 master, register/sample model.
`timescale 1ns/1ps
module tb_accel_spi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo, spi_sdo_oe, sdio_out, sdio_oe;
    logic [15:0] axis_x = '0, axis_y = '0, axis_z = '0;
    logic        sample_valid = 1'b0;
    logic [2:1]  interrupt;

    always #5 clk = ~clk;

    accel_spi_responder dut (
        .clk(clk), .reset_n(reset_n),
        .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .sdio_out(sdio_out), .sdio_oe(sdio_oe),
        .axis_x(axis_x), .axis_y(axis_y), .axis_z(axis_z),
        .sample_valid(sample_valid), .interrupt(interrupt)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    // Reference model state
    logic [7:0]  mem [64];
    logic        m_dr, m_hit, m_pend;
    logic [15:0] p_x, p_y, p_z;
    logic [7:0]  wbuf [8];
    logic [5:0]  wlist [7] = '{6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h31, 6'h00, 6'h32};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        foreach (mem[i]) mem[i] = 8'h00;
        mem[6'h2C] = 8'h0A;
        m_dr = 1'b0; m_hit = 1'b0; m_pend = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return 8'hE5;
        return mem[a];
    endfunction

    task automatic m_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        mem[6'h32] = x[7:0]; mem[6'h33] = x[15:8];
        mem[6'h34] = y[7:0]; mem[6'h35] = y[15:8];
        mem[6'h36] = z[7:0]; mem[6'h37] = z[15:8];
        m_dr = 1'b1;
    endtask

    function automatic logic [1:0] m_int();
        logic src;
        src = m_dr & mem[6'h2E][7];
        return mem[6'h2F][7] ? {src, 1'b0} : {1'b0, src};
    endfunction

    task automatic m_csn_rise();
        if (m_pend) begin
            m_load(p_x, p_y, p_z);
            m_pend = 1'b0;
        end else if (m_hit) begin
            m_dr = 1'b0;
        end
        m_hit = 1'b0;
    endtask

    // One SCLK period: drive on the fall, check output enable at the rise
    task automatic spi_bit(input logic b, input logic exp_oe);
        spi_sclk = 1'b0;
        spi_sdi  = b;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b1;
        check("sdo_oe", 32'(spi_sdo_oe), 32'(exp_oe));
        repeat (HALF) @(negedge clk);
    endtask

    // Full transaction; abort_bits > 0 appends a partial byte before CSN rises
    task automatic spi_xfer(input logic [7:0] cmd, input int nbytes, input int abort_bits);
        logic [5:0] a;
        logic       rd;
        rd = cmd[7];
        a  = cmd[5:0];
        for (int i = 0; i < nbytes; i++) begin
            if (rd) begin
                exp_q.push_back(m_read(a));
                if (a >= 6'h32 && a <= 6'h37) m_hit = 1'b1;
            end else if (a inside {6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h31}) begin
                mem[a] = wbuf[i];
            end
            if (cmd[6]) a = a + 6'd1;
        end
        spi_csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 7; b >= 0; b--) spi_bit(cmd[b], 1'b0);
        for (int i = 0; i < nbytes; i++)
            for (int b = 7; b >= 0; b--) spi_bit(rd ? 1'b0 : wbuf[i][b], rd);
        for (int b = 7; b > 7 - abort_bits; b--) spi_bit(wbuf[nbytes][b], rd);
        repeat (HALF) @(negedge clk);
        spi_csn = 1'b1;
        m_csn_rise();
        repeat (12) @(negedge clk);
        check("sdo_oe_idle", 32'(spi_sdo_oe), 32'h0);
    endtask

    task automatic write1(input logic [5:0] a, input logic [7:0] d);
        wbuf[0] = d;
        spi_xfer({2'b00, a}, 1, 0);
    endtask

    task automatic send_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        axis_x = x; axis_y = y; axis_z = z;
        sample_valid = 1'b1;
        if (spi_csn) m_load(x, y, z);
        else begin
            m_pend = 1'b1; p_x = x; p_y = y; p_z = z;
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic check_int(input string name);
        check(name, 32'(interrupt), 32'(m_int()));
    endtask

    // Monitor: assemble bytes while SDO is enabled and score them on completion
    initial begin : monitor
        logic [7:0] sh;
        int         cnt;
        logic [7:0] exp;
        sh = '0;
        cnt = 0;
        forever begin
            @(posedge spi_sclk or posedge spi_csn or negedge reset_n);
            if (spi_csn || !reset_n) begin
                cnt = 0;
            end else if (spi_sdo_oe) begin
                sh = {sh[6:0], spi_sdo};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sdo_extra_byte got=%0h expected=none", sh);
                    end else begin
                        exp = exp_q.pop_front();
                        check("sdo_byte", 32'(sh), 32'(exp));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [5:0] a;
        int         kind, n;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_sdo", 32'(spi_sdo), 32'h1);
        check("rst_sdo_oe", 32'(spi_sdo_oe), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_sdio", 32'({sdio_out, sdio_oe}), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // DEVID, write/readback, write to read-only address
        spi_xfer(8'h80, 1, 0);
        write1(6'h2D, 8'h08);
        spi_xfer(8'hAD, 1, 0);
        write1(6'h00, 8'h12);
        spi_xfer(8'h80, 1, 0);

        // Sample while idle, INT1, burst read clears DATA_READY
        write1(6'h2E, 8'h80);
        send_sample(16'h0123, 16'hFEDC, 16'h0040);
        repeat (4) @(negedge clk);
        check_int("int1_after_sample");
        spi_xfer(8'hF2, 6, 0);
        check_int("int1_after_burst");

        // Sample arriving mid-burst is deferred until CSN rises
        fork
            spi_xfer(8'hF2, 6, 0);
            begin
                repeat (300) @(negedge clk);
                send_sample(16'h0555, 16'h1111, 16'h2222);
            end
        join
        check_int("int1_pending_applied");
        spi_xfer(8'hB2, 1, 0);
        check_int("int1_after_x0_read");

        // Aborted write byte, then address wrap at 0x3F
        wbuf[0] = 8'hFF;
        spi_xfer(8'h2C, 0, 4);
        spi_xfer(8'hAC, 1, 0);
        spi_xfer(8'hFF, 2, 0);

        // Route to INT2
        write1(6'h2F, 8'h80);
        send_sample(16'hA5A5, 16'h5A5A, 16'h0F0F);
        repeat (4) @(negedge clk);
        check_int("int2_after_sample");

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                a = wlist[$urandom_range(0, 6)];
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom) & 8'hBF;
                spi_xfer({1'b0, 1'($urandom), a}, n, 0);
            end else if (kind == 1) begin
                a = 6'($urandom);
                if ($urandom_range(0, 1) == 1) spi_xfer({2'b11, a}, $urandom_range(1, 3), 0);
                else                           spi_xfer({2'b10, a}, 1, 0);
            end else begin
                send_sample(16'($urandom), 16'($urandom), 16'($urandom));
                repeat (4) @(negedge clk);
            end
            check_int("int_random");
        end

        // Asynchronous reset in the middle of a read data byte
        write1(6'h2E, 8'h80);
        write1(6'h2F, 8'h00);
        send_sample(16'h1234, 16'h5678, 16'h9ABC);
        repeat (4) @(negedge clk);
        check_int("int1_before_reset");
        spi_csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 7; b >= 0; b--) spi_bit(b == 7 ? 1'b1 : 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) spi_bit(1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_mid_sdo_oe", 32'(spi_sdo_oe), 32'h0);
        check("reset_mid_interrupt", 32'(interrupt), 32'h0);
        check("reset_mid_sdo", 32'(spi_sdo), 32'h1);
        spi_csn = 1'b1;
        spi_sclk = 1'b1;
        m_reset();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_xfer(8'hAC, 1, 0);
        spi_xfer(8'hAE, 1, 0);
        check_int("int_after_reset");

        check("sdo_bytes_left", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
